// File: rtl/ts_qos_pkg.sv
// Purpose: shared types and constants for the TS switch sequencer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, channel geometry, sync byte, default timing values.
package ts_qos_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    // First byte of every 188-byte transport stream packet.
    localparam logic [7:0] SYNC_BYTE = 8'h47;

    localparam int DEF_STABLE_CYCLES  = 16;
    localparam int DEF_DWELL_CYCLES   = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STABLE   = 3'd1,
        ST_WAIT_BND = 3'd2,
        ST_SWITCH   = 3'd3,
        ST_DWELL    = 3'd4
    } sw_state_t;

endpackage

// File: rtl/ts_switch_sequencer_if.sv
// Purpose: request/status bundle between main_control, the sequencer and the status registers.
// Latency: n/a (wires only).
// Backpressure: none; the request is level-held by main_control until it is satisfied.
//
// master: main_control side, drives request/valid/boundary/clear, observes mux and stats.
// slave : sequencer side, drives mux select/enable and status, observes the request.
interface ts_switch_sequencer_if import ts_qos_pkg::*; #(
    parameter int CNT_W = 16
) ();

    logic [CH_W-1:0]   req_channel;
    logic              req_en;
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] pkt_boundary;
    logic              clr_stats;

    logic [CH_W-1:0]   mux_sel;
    logic              mux_en;
    logic              busy;
    logic              switch_pulse;
    logic              forced_flag;
    logic [CNT_W-1:0]  switch_count;
    logic [CNT_W-1:0]  timeout_count;

    modport master (
        output req_channel, req_en, valid, pkt_boundary, clr_stats,
        input  mux_sel, mux_en, busy, switch_pulse, forced_flag, switch_count, timeout_count
    );

    modport slave (
        input  req_channel, req_en, valid, pkt_boundary, clr_stats,
        output mux_sel, mux_en, busy, switch_pulse, forced_flag, switch_count, timeout_count
    );

endinterface

// File: rtl/sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; clr wins over inc in the same cycle.
//
// Ports: clk, rst (sync, active high), clr (clear), inc (count enable), count (value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ts_switch_sequencer.sv
// Purpose: turns main_control channel requests into glitch-free TS mux switchovers.
// Latency: normal switch >= STABLE_CYCLES+2 cycles from request; emergency switch 1 cycle.
// Backpressure: none; requests are ignored while a switch is pending or during dwell.
//
// Ports: clk, rst (sync, active high); sw (slave modport) carries the request
// (req_channel, req_en, valid, pkt_boundary, clr_stats) and the results
// (mux_sel, mux_en, busy, switch_pulse, forced_flag, switch_count, timeout_count).
module ts_switch_sequencer import ts_qos_pkg::*; #(
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int DWELL_CYCLES   = DEF_DWELL_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ts_switch_sequencer_if.slave sw
);

    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int DWL_W = $clog2(DWELL_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    sw_state_t        state_q,   state_d;
    logic [CH_W-1:0]  target_q,  target_d;
    logic [STB_W-1:0] stb_q,     stb_d;
    logic [DWL_W-1:0] dwl_q,     dwl_d;
    logic [TMO_W-1:0] tmo_q,     tmo_d;
    logic [CH_W-1:0]  mux_sel_q, mux_sel_d;
    logic             mux_en_q,  mux_en_d;
    logic             forced_q,  forced_d;

    logic emerg;
    logic tmo_evt;
    logic emerg_evt;
    logic busy;
    logic switch_pulse;

    // Active channel has gone dark and main_control is asking for a live one:
    // skip stability and boundary alignment, a glitch beats a dead output.
    assign emerg = mux_en_q
                && !sw.valid[mux_sel_q]
                && sw.req_en
                && (sw.req_channel != mux_sel_q)
                && sw.valid[sw.req_channel];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, timers and target
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        stb_d     = stb_q;
        dwl_d     = dwl_q;
        tmo_d     = tmo_q;
        tmo_evt   = 1'b0;
        emerg_evt = 1'b0;

        if (emerg && (state_q != ST_SWITCH)) begin
            state_d   = ST_SWITCH;
            target_d  = sw.req_channel;
            emerg_evt = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sw.req_en && ((sw.req_channel != mux_sel_q) || !mux_en_q)) begin
                        state_d  = ST_STABLE;
                        target_d = sw.req_channel;
                        stb_d    = '0;
                    end
                end
                ST_STABLE: begin
                    if (!sw.req_en || ((sw.req_channel == mux_sel_q) && mux_en_q)) begin
                        state_d = ST_IDLE;
                    end else if (sw.req_channel != target_q) begin
                        target_d = sw.req_channel;
                        stb_d    = '0;
                    end else if (stb_q == STB_LAST) begin
                        state_d = ST_WAIT_BND;
                        tmo_d   = '0;
                    end else begin
                        stb_d = stb_q + STB_W'(1);
                    end
                end
                ST_WAIT_BND: begin
                    if (sw.req_channel != target_q) begin
                        state_d  = ST_STABLE;
                        target_d = sw.req_channel;
                        stb_d    = '0;
                    end else if (sw.pkt_boundary[target_q] && sw.valid[target_q]) begin
                        // Boundary strobe leads the sync byte by one cycle, so
                        // flipping mux_sel on this edge lands on the sync byte.
                        state_d = ST_SWITCH;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_SWITCH;
                        tmo_evt = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_SWITCH: begin
                    state_d = ST_DWELL;
                    dwl_d   = '0;
                end
                ST_DWELL: begin
                    if (dwl_q == DWL_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        dwl_d = dwl_q + DWL_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // The mux register loads on the edge entering SWITCH, so switch_pulse
        // (decoded from SWITCH) coincides with the first cycle of the new select.
        mux_sel_d = mux_sel_q;
        mux_en_d  = mux_en_q;
        if (state_d == ST_SWITCH) begin
            mux_sel_d = target_d;
            mux_en_d  = 1'b1;
        end

        if (sw.clr_stats) begin
            forced_d = 1'b0;
        end else if (tmo_evt || emerg_evt) begin
            forced_d = 1'b1;
        end else begin
            forced_d = forced_q;
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy         = (state_q != ST_IDLE);
        switch_pulse = (state_q == ST_SWITCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q  <= '0;
            stb_q     <= '0;
            dwl_q     <= '0;
            tmo_q     <= '0;
            mux_sel_q <= '0;
            mux_en_q  <= 1'b0;
            forced_q  <= 1'b0;
        end else begin
            target_q  <= target_d;
            stb_q     <= stb_d;
            dwl_q     <= dwl_d;
            tmo_q     <= tmo_d;
            mux_sel_q <= mux_sel_d;
            mux_en_q  <= mux_en_d;
            forced_q  <= forced_d;
        end
    end

    logic [CNT_W-1:0] switch_count;
    logic [CNT_W-1:0] timeout_count;

    sat_counter #(.W(CNT_W)) u_switch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clr_stats),
        .inc   (switch_pulse),
        .count (switch_count)
    );

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clr_stats),
        .inc   (tmo_evt),
        .count (timeout_count)
    );

    assign sw.mux_sel       = mux_sel_q;
    assign sw.mux_en        = mux_en_q;
    assign sw.busy          = busy;
    assign sw.switch_pulse  = switch_pulse;
    assign sw.forced_flag   = forced_q;
    assign sw.switch_count  = switch_count;
    assign sw.timeout_count = timeout_count;

endmodule

// File: tb/tb_ts_switch_sequencer.sv
module tb_ts_switch_sequencer;
    import ts_qos_pkg::*;

    localparam int STB   = 16;
    localparam int DWL   = 1024;
    localparam int TMO   = 4096;
    // Narrow counters so saturation is reachable in a short run.
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0] sel;
        logic       forced;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ts_switch_sequencer_if #(.CNT_W(CNT_W)) bus ();

    ts_switch_sequencer #(
        .STABLE_CYCLES  (STB),
        .DWELL_CYCLES   (DWL),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   pulse_cnt = 0;
    int   pulse_cyc = 0;
    int   cyc = 0;
    int   exp_sw = 0;
    int   exp_tmo = 0;
    logic [3:0] bnd_mask = 4'h0;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Boundary strobes on enabled channels every 188 cycles.
    initial begin
        int phase;
        phase = 0;
        bus.pkt_boundary = 4'h0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase == 187) ? 0 : phase + 1;
            bus.pkt_boundary = (phase == 0) ? bnd_mask : 4'h0;
        end
    end

    // Scoreboard: every switch_pulse pops the next expected switch.
    initial begin
        exp_t       e;
        logic [3:0] bnd_prev;
        bnd_prev = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst && bus.switch_pulse === 1'b1) begin
                pulse_cnt++;
                pulse_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_switch mux_sel=%0d none expected", bus.mux_sel);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.mux_sel !== e.sel || bus.mux_en !== 1'b1) begin
                        errors++;
                        $display("FAIL switch_target got sel=%0d en=%0b want sel=%0d en=1",
                                 bus.mux_sel, bus.mux_en, e.sel);
                    end
                    if (!e.forced) begin
                        checks++;
                        if (bnd_prev[e.sel] !== 1'b1) begin
                            errors++;
                            $display("FAIL switch_on_boundary got bnd=%b want bit %0d set",
                                     bnd_prev, e.sel);
                        end
                    end
                end
            end
            bnd_prev = bus.pkt_boundary;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int budget, output bit ok);
        int start;
        start = pulse_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (pulse_cnt != start) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req_en = 1'b0;
        bus.req_channel = 2'd0;
        bus.valid = 4'hF;
        bus.clr_stats = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mux_sel !== 2'd0) begin errors++; $display("FAIL reset_mux_sel got %0d want 0", bus.mux_sel); end
        checks++; if (bus.mux_en !== 1'b0) begin errors++; $display("FAIL reset_mux_en got %b want 0", bus.mux_en); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.switch_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", bus.switch_pulse); end
        checks++; if (bus.forced_flag !== 1'b0) begin errors++; $display("FAIL reset_forced got %b want 0", bus.forced_flag); end
        checks++; if (bus.switch_count !== '0) begin errors++; $display("FAIL reset_swcnt got %0d want 0", bus.switch_count); end
        checks++; if (bus.timeout_count !== '0) begin errors++; $display("FAIL reset_tmocnt got %0d want 0", bus.timeout_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_normal_switch();
        bit ok;
        int t0, at;
        bnd_mask = 4'b0100;
        bus.req_channel = 2'd2;
        bus.req_en = 1'b1;
        exp_q.push_back('{sel: 2'd2, forced: 1'b0});
        t0 = cyc;
        wait_pulse(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL normal_pulse got none want pulse within 600"); end
        exp_sw = sat_inc(exp_sw);
        checks++;
        if ((pulse_cyc - t0) < STB + 2 || (pulse_cyc - t0) > STB + 2 + 188) begin
            errors++; $display("FAIL normal_latency got %0d want %0d..%0d", pulse_cyc - t0, STB + 2, STB + 190);
        end
        @(negedge clk);
        checks++; if (bus.switch_count !== CNT_W'(exp_sw)) begin errors++; $display("FAIL normal_swcnt got %0d want %0d", bus.switch_count, exp_sw); end
        checks++; if (bus.forced_flag !== 1'b0) begin errors++; $display("FAIL normal_forced got %b want 0", bus.forced_flag); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL dwell_busy got %b want 1", bus.busy); end
        wait_idle(DWL + 50, ok, at);
        checks++; if (!ok) begin errors++; $display("FAIL dwell_end got busy want idle"); end
        checks++; if (at - pulse_cyc != DWL + 1) begin errors++; $display("FAIL dwell_len got %0d want %0d", at - pulse_cyc, DWL + 1); end
    endtask

    task automatic test_toggle();
        int s;
        s = pulse_cnt;
        bnd_mask = 4'hF;
        for (int i = 0; i < 10; i++) begin
            bus.req_channel = (i % 2 == 0) ? 2'd1 : 2'd3;
            step(8);
        end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL toggle_busy got %b want 1", bus.busy); end
        checks++; if (pulse_cnt != s) begin errors++; $display("FAIL toggle_pulses got %0d want %0d", pulse_cnt, s); end
        checks++; if (bus.switch_count !== CNT_W'(exp_sw)) begin errors++; $display("FAIL toggle_swcnt got %0d want %0d", bus.switch_count, exp_sw); end
        @(posedge clk);
        #1;
        bus.req_channel = 2'd2;
        step(3);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL toggle_idle got %b want 0", bus.busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        bit ok;
        int t0, at;
        bnd_mask = 4'h0;
        bus.req_channel = 2'd3;
        exp_q.push_back('{sel: 2'd3, forced: 1'b1});
        t0 = cyc;
        wait_pulse(STB + TMO + 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_pulse got none want pulse"); end
        exp_sw = sat_inc(exp_sw);
        exp_tmo = sat_inc(exp_tmo);
        checks++; if (pulse_cyc - t0 != STB + TMO + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", pulse_cyc - t0, STB + TMO + 1); end
        @(negedge clk);
        checks++; if (bus.timeout_count !== CNT_W'(exp_tmo)) begin errors++; $display("FAIL timeout_tmocnt got %0d want %0d", bus.timeout_count, exp_tmo); end
        checks++; if (bus.forced_flag !== 1'b1) begin errors++; $display("FAIL timeout_forced got %b want 1", bus.forced_flag); end
        checks++; if (bus.switch_count !== CNT_W'(exp_sw)) begin errors++; $display("FAIL timeout_swcnt got %0d want %0d", bus.switch_count, exp_sw); end
        wait_idle(DWL + 50, ok, at);
    endtask

    task automatic test_emergency();
        bit ok;
        int t0, at;
        bus.clr_stats = 1'b1;
        step(1);
        bus.clr_stats = 1'b0;
        exp_sw = 0;
        exp_tmo = 0;
        @(negedge clk);
        checks++; if (bus.switch_count !== '0 || bus.timeout_count !== '0 || bus.forced_flag !== 1'b0) begin
            errors++; $display("FAIL clr_stats got sw=%0d tmo=%0d f=%b want 0 0 0", bus.switch_count, bus.timeout_count, bus.forced_flag);
        end
        @(posedge clk);
        #1;
        bnd_mask = 4'b0010;
        bus.req_channel = 2'd1;
        exp_q.push_back('{sel: 2'd1, forced: 1'b0});
        wait_pulse(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL emerg_setup got none want pulse"); end
        exp_sw = sat_inc(exp_sw);
        step(20);
        bus.valid = 4'b1101;
        bus.req_channel = 2'd0;
        exp_q.push_back('{sel: 2'd0, forced: 1'b1});
        t0 = cyc;
        wait_pulse(4, ok);
        checks++; if (!ok || pulse_cyc - t0 > 2) begin errors++; $display("FAIL emerg_latency got %0d want <=2", pulse_cyc - t0); end
        exp_sw = sat_inc(exp_sw);
        @(negedge clk);
        checks++; if (bus.forced_flag !== 1'b1) begin errors++; $display("FAIL emerg_forced got %b want 1", bus.forced_flag); end
        checks++; if (bus.timeout_count !== CNT_W'(exp_tmo)) begin errors++; $display("FAIL emerg_tmocnt got %0d want %0d", bus.timeout_count, exp_tmo); end
        checks++; if (bus.switch_count !== CNT_W'(exp_sw)) begin errors++; $display("FAIL emerg_swcnt got %0d want %0d", bus.switch_count, exp_sw); end
        wait_idle(DWL + 50, ok, at);
        bus.valid = 4'hF;
    endtask

    task automatic test_reset_mid();
        int s;
        bnd_mask = 4'h0;
        bus.req_channel = 2'd2;
        step(30);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pending got busy=%b want 1", bus.busy); end
        s = pulse_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mux_sel !== 2'd0 || bus.mux_en !== 1'b0 || bus.busy !== 1'b0 || bus.switch_pulse !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got sel=%0d en=%b busy=%b pulse=%b want 0 0 0 0",
                               bus.mux_sel, bus.mux_en, bus.busy, bus.switch_pulse);
        end
        checks++; if (bus.switch_count !== '0 || bus.timeout_count !== '0 || bus.forced_flag !== 1'b0) begin
            errors++; $display("FAIL midrst_stats got sw=%0d tmo=%0d f=%b want 0 0 0", bus.switch_count, bus.timeout_count, bus.forced_flag);
        end
        exp_sw = 0;
        exp_tmo = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(40);
        checks++; if (pulse_cnt != s) begin errors++; $display("FAIL midrst_no_pulse got %0d want %0d", pulse_cnt, s); end
    endtask

    task automatic test_clr_with_switch();
        bit ok, seen;
        int at;
        bnd_mask = 4'b0010;
        bus.req_channel = 2'd1;
        bus.req_en = 1'b1;
        exp_q.push_back('{sel: 2'd1, forced: 1'b0});
        wait_pulse(600, ok);
        exp_sw = sat_inc(exp_sw);
        wait_idle(DWL + 50, ok, at);
        @(negedge clk);
        checks++; if (bus.switch_count !== CNT_W'(exp_sw)) begin errors++; $display("FAIL clrsw_pre got %0d want %0d", bus.switch_count, exp_sw); end
        @(posedge clk);
        #1;
        bnd_mask = 4'b0100;
        bus.req_channel = 2'd2;
        exp_q.push_back('{sel: 2'd2, forced: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (bus.switch_pulse === 1'b1) seen = 1'b1;
        end
        bus.clr_stats = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_stats = 1'b0;
        exp_sw = 0;
        checks++; if (!seen) begin errors++; $display("FAIL clrsw_pulse got none want pulse"); end
        @(negedge clk);
        checks++; if (bus.switch_count !== '0 || bus.timeout_count !== '0) begin
            errors++; $display("FAIL clrsw_counts got sw=%0d tmo=%0d want 0 0", bus.switch_count, bus.timeout_count);
        end
        wait_idle(DWL + 50, ok, at);
    endtask

    task automatic test_saturate();
        bit ok;
        logic [1:0] cur, nxt;
        cur = 2'd2;
        for (int i = 0; i < CMAX + 2; i++) begin
            nxt = (cur == 2'd2) ? 2'd3 : 2'd2;
            bus.valid = 4'hF & ~(4'b0001 << cur);
            bus.req_channel = nxt;
            exp_q.push_back('{sel: nxt, forced: 1'b1});
            wait_pulse(5, ok);
            exp_sw = sat_inc(exp_sw);
            @(negedge clk);
            checks++; if (!ok || bus.switch_count !== CNT_W'(exp_sw)) begin
                errors++; $display("FAIL sat_step%0d got %0d want %0d", i, bus.switch_count, exp_sw);
            end
            @(posedge clk);
            #1;
            cur = nxt;
        end
        @(negedge clk);
        checks++; if (bus.switch_count !== CNT_W'(CMAX)) begin errors++; $display("FAIL sat_hold got %0d want %0d", bus.switch_count, CMAX); end
        checks++; if (bus.timeout_count !== '0) begin errors++; $display("FAIL sat_tmocnt got %0d want 0", bus.timeout_count); end
        @(posedge clk);
        #1;
        bus.valid = 4'hF;
    endtask

    initial begin
        test_reset();
        test_normal_switch();
        test_toggle();
        test_timeout();
        test_emergency();
        test_reset_mid();
        test_clr_with_switch();
        test_saturate();
        step(5);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
